// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button selection path feeding LED3_control.
//   NUM_BTN          : button count (fixed at 8 by the LED3_control connection)
//   INIT_SEL_DEFAULT : selection presented after reset (one-hot)
//   btn_vec_t        : one bit per button
//   onehot_lowest()  : isolates the lowest set bit of a button vector
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int NUM_BTN = 8;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    localparam btn_vec_t INIT_SEL_DEFAULT = 8'b0000_0001;

    // Two's-complement trick: v & -v keeps only the lowest set bit, so
    // simultaneous presses resolve to the lowest index. Zero maps to zero.
    function automatic btn_vec_t onehot_lowest(input btn_vec_t v);
        return v & (~v + btn_vec_t'(1));
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One button lane: 2-flop synchroniser, stability counter, accepted (stable)
// level and a registered one-cycle pulse on each accepted 0->1 transition.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous, active-low reset
//   i_raw   : asynchronous pin level, already polarity-corrected (1 = pressed)
//   o_level : debounced level
//   o_rise  : combinational, high in the cycle right after o_level rises
//   o_pulse : o_rise registered; high for exactly one cycle per press
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_pulse
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: every flop in a clocked block uses <= so all of them sample the
    // pre-edge values; blocking = here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_pulse    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_pulse    <= o_rise;

            // Any return to the accepted level restarts the count, so only an
            // unbroken run of DEBOUNCE_CYCLES mismatching cycles is accepted.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_stable & ~r_stable_d;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_select_debounce.sv
// -----------------------------------------------------------------------------
// btn_select_debounce
// Debounces eight raw button pins and keeps a held one-hot selection for
// LED3_control: the most recent debounced press owns the selection.
// Ports:
//   clk       : 1 MHz system clock, rising edge
//   rst       : asynchronous, active-low reset
//   btn_raw   : asynchronous button pins (polarity set by BTN_ACTIVE_HIGH)
//   btn       : held one-hot selection (always exactly one bit set)
//   btn_pulse : one-cycle pulse per debounced press, releases give no pulse
//   btn_level : debounced pressed level per button
// -----------------------------------------------------------------------------
module btn_select_debounce
    import btn_pkg::*;
#(
    parameter int       NUM_BTN         = btn_pkg::NUM_BTN,
    parameter int       DEBOUNCE_CYCLES = 10000,
    parameter btn_vec_t INIT_SEL        = btn_pkg::INIT_SEL_DEFAULT,
    parameter bit       BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level
);

    logic [NUM_BTN-1:0] w_btn_in;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_pulse;
    logic [NUM_BTN-1:0] w_sel_next;
    logic [NUM_BTN-1:0] r_btn;

    // Inversion happens ahead of the synchroniser so every lane downstream
    // works in "1 = pressed" terms regardless of board wiring.
    assign w_btn_in = BTN_ACTIVE_HIGH ? btn_raw : ~btn_raw;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (w_btn_in[i]),
            .o_level (w_level[i]),
            .o_rise  (w_rise[i]),
            .o_pulse (w_pulse[i])
        );
    end

    // The selection is driven from the unregistered rise so that btn changes
    // on the same edge that raises btn_pulse. Because w_rise is non-zero
    // whenever it is used, the loaded value is always one-hot.
    always_comb begin
        // NOTE: default first so every path assigns w_sel_next; otherwise a
        // latch would be inferred to hold the value.
        w_sel_next = r_btn;
        if (|w_rise) begin
            w_sel_next = onehot_lowest(w_rise);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn <= INIT_SEL;
        end else begin
            r_btn <= w_sel_next;
        end
    end

    assign btn       = r_btn;
    assign btn_pulse = w_pulse;
    assign btn_level = w_level;

endmodule

// File: tb/tb_btn_select_debounce.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_btn_select_debounce
// Directed stimulus with DEBOUNCE_CYCLES = 4 and a 1 us clock. Each press that
// should produce a pulse pushes {due cycle, pulse, selection} into a queue; a
// monitor on the falling edge pops one entry whenever btn_pulse is non-zero.
// -----------------------------------------------------------------------------
module tb_btn_select_debounce;

    localparam int DC       = 4;
    localparam int LAT      = DC + 3;   // stimulus negedge -> pulse observed
    localparam int REL_LAT  = DC + 2;   // stimulus negedge -> level observed

    typedef struct {
        int         cyc;
        logic [7:0] pulse;
        logic [7:0] sel;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] btn_raw;
    logic [7:0] btn;
    logic [7:0] btn_pulse;
    logic [7:0] btn_level;

    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    btn_select_debounce #(
        .NUM_BTN         (8),
        .DEBOUNCE_CYCLES (DC),
        .INIT_SEL        (8'b0000_0001),
        .BTN_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn       (btn),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_press(input logic [7:0] pulse, input logic [7:0] sel);
        exp_t e;
        e.cyc   = cyc + LAT;
        e.pulse = pulse;
        e.sel   = sel;
        sb_q.push_back(e);
    endtask

    // Monitor: every non-zero btn_pulse must match the next expected press.
    always @(negedge clk) begin
        if (btn_pulse !== 8'h00) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got %0h, expected none (cycle %0d)", btn_pulse, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_value", {24'h0, btn_pulse}, {24'h0, e.pulse});
                check("pulse_sel", {24'h0, btn}, {24'h0, e.sel});
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b0;
        btn_raw = 8'h00;

        // Reset and idle hold
        tick(3);
        check("rst_btn", btn, 8'h01);
        check("rst_pulse", btn_pulse, 8'h00);
        check("rst_level", btn_level, 8'h00);
        rst = 1'b1;
        tick(6);
        check("idle_btn", btn, 8'h01);
        check("idle_level", btn_level, 8'h00);

        // Clean press of bit 2, then release
        btn_raw = 8'b0000_0100;
        expect_press(8'b0000_0100, 8'b0000_0100);
        tick(LAT);
        check("clean_level", btn_level, 8'h04);
        tick(3);
        check("clean_btn_hold", btn, 8'h04);
        btn_raw = 8'h00;
        tick(REL_LAT - 1);
        check("release_level_early", btn_level, 8'h04);
        tick(1);
        check("release_level", btn_level, 8'h00);
        check("release_btn", btn, 8'h04);
        tick(3);

        // Bounce rejection on bit 5
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0) ? 8'h20 : 8'h00;
            tick(1);
        end
        btn_raw = 8'h00;
        tick(3);
        for (int g = 0; g < 2; g++) begin
            btn_raw = 8'h20;
            tick(3);
            btn_raw = 8'h00;
            tick(3);
        end
        tick(6);
        check("bounce_level", btn_level, 8'h00);
        check("bounce_btn", btn, 8'h04);
        btn_raw = 8'h20;
        expect_press(8'h20, 8'h20);
        tick(LAT + 1);
        check("steady5_level", btn_level, 8'h20);
        btn_raw = 8'h00;
        tick(REL_LAT + 2);

        // Simultaneous press of bits 6 and 3
        btn_raw = 8'b0100_1000;
        expect_press(8'b0100_1000, 8'b0000_1000);
        tick(LAT + 1);
        check("simul_level", btn_level, 8'h48);
        btn_raw = 8'h00;
        tick(REL_LAT + 2);
        check("simul_btn_hold", btn, 8'h08);

        // Last press wins while another is held
        btn_raw = 8'h02;
        expect_press(8'h02, 8'h02);
        tick(LAT + 1);
        btn_raw = 8'h82;
        expect_press(8'h80, 8'h80);
        tick(LAT + 1);
        check("held_level", btn_level, 8'h82);
        btn_raw = 8'h02;
        tick(REL_LAT + 2);
        check("rel7_btn", btn, 8'h80);
        check("rel7_level", btn_level, 8'h02);
        // Re-press of the already selected button pulses again
        btn_raw = 8'h82;
        expect_press(8'h80, 8'h80);
        tick(LAT + 1);
        btn_raw = 8'h00;
        tick(REL_LAT + 2);
        check("repress_btn", btn, 8'h80);

        // Reset mid-debounce with bit 4 held through release
        btn_raw = 8'h10;
        tick(4);
        #200;
        rst = 1'b0;
        #1;
        check("async_btn", btn, 8'h01);
        check("async_pulse", btn_pulse, 8'h00);
        check("async_level", btn_level, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        expect_press(8'h10, 8'h10);
        tick(LAT - 2);
        check("redebounce_btn_init", btn, 8'h01);
        tick(3);
        check("redebounce_btn", btn, 8'h10);
        check("redebounce_level", btn_level, 8'h10);
        btn_raw = 8'h00;
        tick(REL_LAT + 2);

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
